// File: rtl/mult_frame_sequencer.sv
// Parses HEADER/A/B byte frames, runs an 8-cycle shift-add multiply and streams the product out over the UART TX handshake.
// Optional MULT_SEQ_CHECKSUM_EN appends a third response byte, result[15:8] ^ result[7:0].
module mult_frame_sequencer #(
  parameter logic [7:0] HEADER  = 8'hA5,
  parameter int         TIMEOUT = 1000,
  parameter int         DATA_W  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_W-1:0]   rx_data,
  input  logic                rx_valid,
  input  logic                tx_ready,
  output logic [DATA_W-1:0]   tx_data,
  output logic                tx_start,
  output logic [2*DATA_W-1:0] result,
  output logic                result_valid,
  output logic                busy,
  output logic                frame_err
);

  localparam int GAP_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int PROD_W = 2 * DATA_W;
  localparam int STEP_W = $clog2(DATA_W + 1);

  typedef enum logic [3:0] {
    IDLE,
    GET_A,
    GET_B,
    MULT,
    SEND_HI,
    WAIT_HI,
    SEND_LO,
    WAIT_LO
`ifdef MULT_SEQ_CHECKSUM_EN
    ,
    SEND_CK,
    WAIT_CK
`endif
  } state_t;

  state_t              state;
  state_t              state_nxt;

  logic [DATA_W-1:0]   op_a;
  logic [DATA_W-1:0]   op_b;
  logic [PROD_W-1:0]   mcand;
  logic [PROD_W-1:0]   acc;
  logic [STEP_W-1:0]   step;
  logic [GAP_W-1:0]    gap;

  logic                ld_a;
  logic                ld_b;
  logic                err_set;
  logic                step_en;
  logic                mult_done;
  logic                tx_load;
  logic [DATA_W-1:0]   tx_byte;
  logic                gap_run;
  logic                gap_clr;
  logic                timeout_hit;

  function automatic logic [PROD_W-1:0] mac_step(input logic [PROD_W-1:0] acc_in,
                                                 input logic [PROD_W-1:0] addend,
                                                 input logic              bit_en);
    return bit_en ? acc_in + addend : acc_in;
  endfunction

`ifdef MULT_SEQ_CHECKSUM_EN
  function automatic logic [DATA_W-1:0] checksum(input logic [PROD_W-1:0] prod);
    return prod[PROD_W-1:DATA_W] ^ prod[DATA_W-1:0];
  endfunction
`endif

  assign busy        = (state != IDLE);
  assign timeout_hit = (TIMEOUT != 0) && (gap == GAP_W'(TIMEOUT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ld_a      = 1'b0;
    ld_b      = 1'b0;
    err_set   = 1'b0;
    step_en   = 1'b0;
    mult_done = 1'b0;
    tx_load   = 1'b0;
    tx_byte   = '0;
    gap_run   = 1'b0;
    gap_clr   = 1'b1;
    case (state)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data == HEADER) begin
            state_nxt = GET_A;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      GET_A: begin
        gap_clr = 1'b0;
        // Timeout takes priority over a byte arriving in the same cycle.
        if (timeout_hit) begin
          err_set   = 1'b1;
          state_nxt = IDLE;
        end else if (rx_valid) begin
          ld_a      = 1'b1;
          gap_clr   = 1'b1;
          state_nxt = GET_B;
        end else begin
          gap_run = 1'b1;
        end
      end
      GET_B: begin
        gap_clr = 1'b0;
        if (timeout_hit) begin
          err_set   = 1'b1;
          state_nxt = IDLE;
        end else if (rx_valid) begin
          ld_b      = 1'b1;
          gap_clr   = 1'b1;
          state_nxt = MULT;
        end else begin
          gap_run = 1'b1;
        end
      end
      MULT: begin
        if (step == STEP_W'(DATA_W)) begin
          mult_done = 1'b1;
          state_nxt = SEND_HI;
        end else begin
          step_en = 1'b1;
        end
      end
      SEND_HI: begin
        if (tx_ready) begin
          tx_load   = 1'b1;
          tx_byte   = result[PROD_W-1:DATA_W];
          state_nxt = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (!tx_ready) begin
          state_nxt = SEND_LO;
        end
      end
      SEND_LO: begin
        if (tx_ready) begin
          tx_load   = 1'b1;
          tx_byte   = result[DATA_W-1:0];
          state_nxt = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (!tx_ready) begin
`ifdef MULT_SEQ_CHECKSUM_EN
          state_nxt = SEND_CK;
`else
          state_nxt = IDLE;
`endif
        end
      end
`ifdef MULT_SEQ_CHECKSUM_EN
      SEND_CK: begin
        if (tx_ready) begin
          tx_load   = 1'b1;
          tx_byte   = checksum(result);
          state_nxt = WAIT_CK;
        end
      end
      WAIT_CK: begin
        if (!tx_ready) begin
          state_nxt = IDLE;
        end
      end
`endif
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand capture and shift-add datapath, one multiplier bit per cycle, LSB first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_a  <= '0;
      op_b  <= '0;
      mcand <= '0;
      acc   <= '0;
      step  <= '0;
      gap   <= '0;
    end else begin
      if (ld_a) begin
        op_a <= rx_data;
      end
      if (ld_b) begin
        op_b  <= rx_data;
        mcand <= {{DATA_W{1'b0}}, op_a};
        acc   <= '0;
        step  <= '0;
      end else if (step_en) begin
        acc   <= mac_step(acc, mcand, op_b[0]);
        mcand <= mcand << 1;
        op_b  <= op_b >> 1;
        step  <= step + STEP_W'(1);
      end
      if (gap_clr) begin
        gap <= '0;
      end else if (gap_run) begin
        gap <= gap + GAP_W'(1);
      end
    end
  end

  // Registered outputs: single-cycle pulses and held result/tx byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_data      <= '0;
      tx_start     <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      tx_start     <= tx_load;
      result_valid <= mult_done;
      frame_err    <= err_set;
      if (tx_load) begin
        tx_data <= tx_byte;
      end
      if (mult_done) begin
        result <= acc;
      end
    end
  end

endmodule

// File: tb/tb_mult_frame_sequencer.sv
// Scoreboard bench for mult_frame_sequencer: directed frames, a simple UART TX model and a decoupled output monitor.
module tb_mult_frame_sequencer;

  localparam logic [7:0] HEADER  = 8'hA5;
  localparam int         TIMEOUT = 1000;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic [15:0] result;
  logic        result_valid;
  logic        busy;
  logic        frame_err;

  int checks = 0;
  int errors = 0;
  int uart_cnt = 0;
  logic hold_low = 1'b0;
  logic prev_start = 1'b0;

  logic [15:0] exp_res[$];
  logic [7:0]  exp_tx[$];
  int          exp_err = 0;
  logic [15:0] pop_res;
  logic [7:0]  pop_tx;

  mult_frame_sequencer #(.HEADER(HEADER), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .reset(reset),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .tx_ready(tx_ready),
    .tx_data(tx_data),
    .tx_start(tx_start),
    .result(result),
    .result_valid(result_valid),
    .busy(busy),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // UART TX model: busy for 6 cycles after each accepted start; hold_low forces not-ready.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (tx_start) begin
        uart_cnt = 6;
      end else if (uart_cnt != 0) begin
        uart_cnt--;
      end
      tx_ready = (uart_cnt == 0) && !hold_low;
    end
  end

  // Monitor: pops expectations whenever the DUT presents an output.
  always @(negedge clk) begin
    if (!reset) begin
      if (result_valid) begin
        if (exp_res.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: got %0h, expected no result", result);
        end else begin
          pop_res = exp_res.pop_front();
          chk("result", result, pop_res);
        end
      end
      if (tx_start) begin
        chk("tx_start_back_to_back", prev_start, 0);
        if (exp_tx.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_tx: got %0h, expected no tx byte", tx_data);
        end else begin
          pop_tx = exp_tx.pop_front();
          chk("tx_byte", tx_data, pop_tx);
        end
      end
      if (frame_err) begin
        checks++;
        if (exp_err == 0) begin
          errors++;
          $display("FAIL unexpected_frame_err: got 1, expected 0");
        end else begin
          exp_err--;
        end
      end
    end
    prev_start = tx_start;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic push_resp(input logic [15:0] p);
    exp_res.push_back(p);
    exp_tx.push_back(p[15:8]);
    exp_tx.push_back(p[7:0]);
`ifdef MULT_SEQ_CHECKSUM_EN
    exp_tx.push_back(p[15:8] ^ p[7:0]);
`endif
  endtask

  task automatic run_frame(input logic [7:0] a, input logic [7:0] b,
                           input logic [15:0] p, input bit chk_tx);
    int lat;
    push_resp(p);
    send_byte(HEADER);
    send_byte(a);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    lat = 0;
    while (!result_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("result_latency", lat, 9);
    if (chk_tx) begin
      @(posedge clk);
      #1;
      chk("tx_start_latency", tx_start, 1);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || exp_tx.size() != 0 || !tx_ready) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL wait_idle: busy=%0b pending_tx=%0d, expected idle within 3000 cycles", busy, exp_tx.size());
    end
  endtask

  initial begin
    int starts;
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_result", result, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_err", frame_err, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    run_frame(8'h0C, 8'h0D, 16'h009C, 1'b1);
    wait_idle();

    run_frame(8'hFF, 8'hFF, 16'hFE01, 1'b0);
    wait_idle();
    chk("busy_after_ff", busy, 0);

    exp_err++;
    send_byte(8'h3C);
    run_frame(8'h02, 8'h03, 16'h0006, 1'b0);
    wait_idle();

    // Partial frame then silence: error must not appear early.
    send_byte(HEADER);
    send_byte(8'h07);
    repeat (TIMEOUT - 10) @(negedge clk);
    chk("busy_before_timeout", busy, 1);
    exp_err++;
    repeat (30) @(negedge clk);
    chk("busy_after_timeout", busy, 0);
    chk("timeout_err_seen", exp_err, 0);
    run_frame(8'h01, 8'h01, 16'h0001, 1'b0);
    wait_idle();

    // tx_ready held low: no start, extra rx bytes dropped silently.
    hold_low = 1'b1;
    repeat (2) @(negedge clk);
    run_frame(8'h04, 8'h05, 16'h0014, 1'b0);
    starts = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      rx_valid = (i == 5) || (i == 9);
      rx_data  = (i == 5) ? HEADER : 8'h3C;
      if (tx_start) starts++;
    end
    rx_valid = 1'b0;
    chk("hold_no_tx_start", starts, 0);
    chk("hold_busy", busy, 1);
    hold_low = 1'b0;
    wait_idle();

    // Reset during MULT: nothing of that frame may be emitted.
    send_byte(HEADER);
    send_byte(8'h06);
    send_byte(8'h07);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_tx_start", tx_start, 0);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_result_valid", result_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_frame_err", frame_err, 0);
    chk("mid_rst_tx_data", tx_data, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    run_frame(8'h0A, 8'h0B, 16'h006E, 1'b0);
    wait_idle();

    repeat (5) @(negedge clk);
    chk("pending_results", exp_res.size(), 0);
    chk("pending_tx", exp_tx.size(), 0);
    chk("pending_errs", exp_err, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mult_frame_sequencer.md
# mult_frame_sequencer

Command sequencer that turns the UART receive byte stream into multiply operations and streams the products back out through the UART transmitter. It parses three-byte frames (header, operand A, operand B), runs a sequential 8x8 shift-add multiply, then hands the 16-bit product to the transmitter one byte at a time using its start/ready handshake. It sits between the UART RX/TX cores inside `uart_spi_top` and owns the UART TX port whenever a response is pending.

## Interface
- `HEADER`, 8'hA5, frame start byte.
- `TIMEOUT`, 1000, maximum clk cycles allowed between frame bytes; 0 disables the timeout.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `rx_data` in 8: received byte, valid when `rx_valid`=1.
- `rx_valid` in 1: one-cycle pulse per received byte.
- `tx_ready` in 1: UART transmitter idle; drops within 1 cycle of accepting `tx_start`.
- `tx_data` out 8: byte to transmit; stable from `tx_start` until the next `tx_start`.
- `tx_start` out 1: one-cycle transmit request.
- `result` out 16: last product; holds until the next product.
- `result_valid` out 1: one-cycle pulse when `result` updates.
- `busy` out 1: high in any state other than IDLE.
- `frame_err` out 1: one-cycle pulse on a bad header or timeout.

## Operation
- States: IDLE, GET_A, GET_B, MULT, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO (plus SEND_CK, WAIT_CK with checksum enabled).
- IDLE: if `rx_valid` and `rx_data`==`HEADER`, go to GET_A. If `rx_valid` with any other byte, pulse `frame_err` and stay in IDLE.
- GET_A / GET_B: latch `rx_data` into A or B on `rx_valid`. A gap counter clears on every accepted byte. When it reaches `TIMEOUT`, pulse `frame_err`, discard the partial frame and return to IDLE. Any byte value is accepted as an operand, including `HEADER`.
- MULT: unsigned shift-add, one multiplier bit per cycle, LSB first. Takes exactly 8 cycles. The 16-bit accumulator cannot overflow. On exit, load `result` and pulse `result_valid`.
- SEND_x: when `tx_ready`=1, register `tx_data` (HI=`result[15:8]`, LO=`result[7:0]`), pulse `tx_start` and go to WAIT_x.
- WAIT_x: when `tx_ready`=0, go to the next SEND state. After the last WAIT, return to IDLE. There is no timeout while sending.
- `rx_valid` in MULT, SEND_* or WAIT_* is ignored and dropped, and raises no `frame_err`.

## Timing
- Reset values: `tx_data`=0, `tx_start`=0, `result`=0, `result_valid`=0, `busy`=0, `frame_err`=0, state=IDLE, A=B=0, gap counter=0.
- Reset asserted mid-frame or mid-send forces IDLE and drops `tx_start` asynchronously. A byte already started in the UART is not recalled.
- If operand B is accepted at edge N:
  - MULT occupies cycles N+1..N+8.
  - `result`/`result_valid` update at edge N+9, which also enters SEND_HI.
  - With `tx_ready` already high, `tx_start` goes high in the cycle after edge N+10.
- Header to result latency with back-to-back bytes: bytes spacing + 9 cycles after the B byte.
- `tx_start` is registered and never asserted in two consecutive cycles.
- `frame_err` and `result_valid` are registered single-cycle pulses.
- Timeout fires on the cycle the gap counter equals `TIMEOUT`, measured from the previous accepted byte's edge.
- `rx_valid` in the same cycle as a timeout: the timeout wins and the byte is dropped.

## Configuration
- `MULT_SEQ_CHECKSUM_EN` defined: after LO, a third byte `result[15:8]^result[7:0]` is sent through SEND_CK/WAIT_CK before returning to IDLE.
- Not defined: the response is exactly two bytes (HI, LO). SEND_CK and WAIT_CK do not exist.

## Test plan
- Frame A5,0C,0D with `tx_ready` held high and a UART model → `result`=16'h009C with one `result_valid` pulse. TX bytes are 00 then 9C, plus 9C with checksum enabled.
- Frame A5,FF,FF → `result`=16'hFE01. TX bytes are FE, 01, plus FF with checksum enabled. `busy` returns to 0 after the last byte.
- Byte 3C in IDLE, then A5,02,03 → one `frame_err` pulse for 3C, then `result`=0006.
- A5,07, then silence for `TIMEOUT` cycles → `frame_err` pulse, `busy`=0. A following A5,01,01 yields `result`=0001.
- `tx_ready` held low for 50 cycles after MULT → no `tx_start` until `tx_ready` rises. Extra `rx_valid` bytes during this wait are dropped.
- `reset` pulsed during the MULT cycles → all outputs at reset values, no `tx_start` issued, and the next valid frame works normally.
